alu_arb_ctrl: RTL and testbench

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_arb_ctrl.sv | 113 +++++++++++
 tb/tb_alu_arb_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for a shared external 4-bit ALU.
// Each transaction walks IDLE -> EXEC -> RESP and returns a registered 8-bit result split into two nibbles.
module alu_arb_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] op0,
    input  logic [3:0] op1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [3:0] alu_x,
    input  logic [3:0] alu_y,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] res_x,
    output logic [3:0] res_y,
    output logic       busy,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] dbg_state
);

    // Handshake: reqN is a level request sampled only in IDLE; gntN pulses for the
    // single EXEC cycle, after which the requester drops reqN; doneN pulses for the
    // single RESP cycle while res_x/res_y and cntN already hold the new values.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;
    logic   owner;
    logic   start;
    logic   pick1;
    logic   keep_y;

    // Requester 1 wins when it is alone or when both ask and the pointer names it.
    assign start  = req0 | req1;
    assign pick1  = req1 & (~req0 | ptr);
    assign keep_y = (alu_op == 4'b1010) || (alu_op == 4'b1100) ||
                    (alu_op == 4'b1101) || (alu_op == 4'b1110);

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                gnt0      = ~owner;
                gnt1      = owner;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                done0     = ~owner;
                done1     = owner;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            alu_op <= 4'd0;
            alu_a  <= 4'd0;
            alu_b  <= 4'd0;
            res_x  <= 4'd0;
            res_y  <= 4'd0;
            cnt0   <= 8'd0;
            cnt1   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                owner  <= pick1;
                alu_op <= pick1 ? op1 : op0;
                alu_a  <= pick1 ? a1  : a0;
                alu_b  <= pick1 ? b1  : b0;
            end
            // Leaving EXEC: capture the ALU, hand priority to the other side, count the completion.
            if (state == S_EXEC) begin
                res_x <= alu_x;
                res_y <= keep_y ? alu_y : 4'd0;
                ptr   <= ~owner;
                if (owner) cnt1 <= cnt1 + 8'd1;
                else       cnt0 <= cnt0 + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Randomized bench for alu_arb_ctrl: a behavioural ALU drives alu_x/alu_y, and a
// transaction-level model predicts winner, result, pointer and counters.
module tb_alu_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] op0, op1, a0, b0, a1, b1;
    logic [3:0] alu_x, alu_y;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [3:0] res_x, res_y, alu_op, alu_a, alu_b;
    logic [7:0] cnt0, cnt1;
    logic [1:0] dbg_state;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_ptr;
    int         m_cnt[2];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_arb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .alu_x(alu_x), .alu_y(alu_y),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res_x(res_x), .res_y(res_y), .busy(busy),
        .cnt0(cnt0), .cnt1(cnt1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .dbg_state(dbg_state)
    );

    // External ALU: 8-bit result {y, x}; non-arithmetic ops report y = 1111 so masking is visible.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'b1010: return {4'd0, a} + {4'd0, b};
            4'b1100: return {4'd0, a} * {4'd0, b};
            4'b1101: return {4'd0, a} - {4'd0, b};
            4'b1110: return {a, b};
            4'b0011: return {4'hF, a & b};
            default: return {4'hF, a ^ b};
        endcase
    endfunction

    always_comb {alu_y, alu_x} = alu_fn(alu_op, alu_a, alu_b);

    function automatic logic [7:0] expect_res(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        r = alu_fn(op, a, b);
        if (!(op inside {4'b1010, 4'b1100, 4'b1101, 4'b1110})) r[7:4] = 4'd0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_reset_vals();
        check("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_done",  {30'd0, done1, done0}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_res",   {24'd0, res_y, res_x}, 32'd0);
        check("rst_alu",   {20'd0, alu_op, alu_a, alu_b}, 32'd0);
        check("rst_cnt",   {16'd0, cnt1, cnt0}, 32'd0);
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        exp_q.delete();
    endtask

    // Called at a negedge with the DUT idle; serves every raised request, then returns idle.
    task automatic serve(input bit r0, input bit r1,
                         input logic [3:0] o0, input logic [3:0] x0, input logic [3:0] y0,
                         input logic [3:0] o1, input logic [3:0] x1, input logic [3:0] y1);
        bit         pend0, pend1;
        int         w;
        logic [3:0] wop, wa, wb;
        logic [7:0] exp_r;
        req0 = r0; op0 = o0; a0 = x0; b0 = y0;
        req1 = r1; op1 = o1; a1 = x1; b1 = y1;
        pend0 = r0;
        pend1 = r1;
        while (pend0 || pend1) begin
            w   = (pend0 && pend1) ? m_ptr : (pend1 ? 1 : 0);
            wop = (w == 1) ? op1 : op0;
            wa  = (w == 1) ? a1  : a0;
            wb  = (w == 1) ? b1  : b0;
            exp_q.push_back(expect_res(wop, wa, wb));
            @(negedge clk);
            check("exec_gnt0", {31'd0, gnt0}, (w == 0) ? 32'd1 : 32'd0);
            check("exec_gnt1", {31'd0, gnt1}, (w == 1) ? 32'd1 : 32'd0);
            check("exec_busy", {31'd0, busy}, 32'd1);
            check("exec_done", {30'd0, done1, done0}, 32'd0);
            // Winner withdraws and scrambles its operands; the result must not change.
            if (w == 0) begin
                req0 = 1'b0; op0 = 4'($urandom); a0 = 4'($urandom); b0 = 4'($urandom); pend0 = 1'b0;
            end else begin
                req1 = 1'b0; op1 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom); pend1 = 1'b0;
            end
            m_cnt[w] = (m_cnt[w] + 1) % 256;
            m_ptr    = 1 - w;
            @(negedge clk);
            check("resp_done0", {31'd0, done0}, (w == 0) ? 32'd1 : 32'd0);
            check("resp_done1", {31'd0, done1}, (w == 1) ? 32'd1 : 32'd0);
            check("resp_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                exp_r = exp_q.pop_front();
                check("resp_res", {24'd0, res_y, res_x}, {24'd0, exp_r});
            end
            check("resp_cnt0", {24'd0, cnt0}, 32'(m_cnt[0]));
            check("resp_cnt1", {24'd0, cnt1}, 32'(m_cnt[1]));
            check("resp_alu_drive", {20'd0, alu_op, alu_a, alu_b}, {20'd0, wop, wa, wb});
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {30'd0, done1, done0}, 32'd0);
            if (exp_r != 8'd0) check("hold_res", {24'd0, res_y, res_x}, {24'd0, exp_r});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bit r0, r1;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 4'd0; op1 = 4'd0; a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        // Both requesters right after reset: requester 0 first, then 1.
        serve(1'b1, 1'b1, 4'b1010, 4'd3, 4'd4, 4'b1100, 4'd2, 4'd7);

        // No request: stays idle.
        repeat (3) begin
            @(negedge clk);
            check("no_req_idle", {29'd0, busy, gnt1, gnt0}, 32'd0);
        end

        do_reset();
        serve(1'b1, 1'b0, 4'b1010, 4'b1001, 4'b1000, 4'd0, 4'd0, 4'd0);
        check("dir_add", {16'd0, res_y, res_x, cnt0}, {16'd0, 4'b0001, 4'b0001, 8'd1});
        serve(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'b1100, 4'b1111, 4'b1111);
        check("dir_mul", {16'd0, res_y, res_x, cnt1}, {16'd0, 4'b1110, 4'b0001, 8'd1});
        serve(1'b1, 1'b0, 4'b0011, 4'b1100, 4'b1010, 4'd0, 4'd0, 4'd0);
        check("dir_mask", {24'd0, res_y, res_x}, {24'd0, 4'b0000, 4'b1000});

        // Reset pulsed during EXEC aborts the transaction.
        do_reset();
        req0 = 1'b1; op0 = 4'b1010; a0 = 4'd5; b0 = 4'd6;
        @(negedge clk);
        check("abort_gnt0", {31'd0, gnt0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {22'd0, done1, done0, cnt0}, 32'd0);
        end
        serve(1'b1, 1'b0, 4'b1101, 4'd9, 4'd2, 4'd0, 4'd0, 4'd0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            serve(r0, r1, 4'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // 256 completions on requester 0 wrap its counter back to zero.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            serve(1'b1, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'd0, 4'd0, 4'd0);
        end
        check("wrap_cnt0", {24'd0, cnt0}, 32'd0);
        check("wrap_cnt1", {24'd0, cnt1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
